// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared constants and parameter helpers for the pipelined CLA adder/subtractor.
// Latency: none (package only).
// Backpressure: not applicable.
package pipelined_cla_addsub_pkg;

    // Operation select encoding for i_sub
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Bits handled by each pipeline stage
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Legal geometry: at least 2 bits, and the stage count splits the width evenly
    function automatic bit geometry_ok(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/cla_slice.sv
// One carry-lookahead slice: sum, carry out and carry into the top bit.
// Latency: purely combinational.
// Backpressure: none; the caller owns all sequencing.
module cla_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [W-1:0] g_w;
    logic [W-1:0] p_w;
    logic [W:0]   c_w;

    // Generate/propagate terms and the lookahead carry recurrence
    always_comb begin
        g_w    = a & b;
        p_w    = a | b;
        c_w    = '0;
        c_w[0] = cin;
        for (int i = 0; i < W; i++) begin
            c_w[i+1] = g_w[i] | (p_w[i] & c_w[i]);
        end
        sum   = a ^ b ^ c_w[W-1:0];
        cout  = c_w[W];
        c_msb = c_w[W-1];
    end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA adder/subtractor; one slice per stage, inter-slice carry registered.
// Latency: STAGES enabled cycles from accept to o_valid; one beat per cycle throughput.
// Backpressure: full stall when o_valid & !i_ready; o_ready is the shared stage enable.
module pipelined_cla_addsub
    import pipelined_cla_addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int SLICE_W = slice_width(WIDTH, STAGES);

    if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
        $error("pipelined_cla_addsub: WIDTH must be >= 2 and divisible by STAGES");
    end

    // Per-stage registers. Stage k holds the beat after slice k has been summed;
    // operands ride along so later stages can pick their own slice.
    logic             vld_q [STAGES];
    logic             sub_q [STAGES];
    logic             cy_q  [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             ovf_q;

    // Stage inputs: ports for stage 0, previous stage registers otherwise
    logic             vld_in [STAGES];
    logic             sub_in [STAGES];
    logic             cin_in [STAGES];
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] b_eff  [STAGES];
    logic [WIDTH-1:0] sum_in [STAGES];

    // Slice results and next-state sums
    logic [WIDTH-1:0] slice_sum_w;
    logic             cout_w [STAGES];
    logic             cmsb_w [STAGES];
    logic [WIDTH-1:0] sum_d  [STAGES];
    logic             ovf_d;
    logic             en;

    // Whole pipe advances together; it only stops when a finished beat is not taken
    assign en      = !vld_q[STAGES-1] || i_ready;
    assign o_ready = en;

    // Route each stage's operands, carry and partial sum from its predecessor
    always_comb begin
        vld_in[0] = i_valid;
        sub_in[0] = i_sub;
        cin_in[0] = (i_sub != MODE_ADD);
        a_in[0]   = i_a;
        b_in[0]   = i_b;
        sum_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            vld_in[k] = vld_q[k-1];
            sub_in[k] = sub_q[k-1];
            cin_in[k] = cy_q[k-1];
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            sum_in[k] = sum_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            b_eff[k] = b_in[k] ^ {WIDTH{sub_in[k] == MODE_SUB}};
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        cla_slice #(
            .W(SLICE_W)
        ) u_cla_slice (
            .a     (a_in[k][k*SLICE_W +: SLICE_W]),
            .b     (b_eff[k][k*SLICE_W +: SLICE_W]),
            .cin   (cin_in[k]),
            .sum   (slice_sum_w[k*SLICE_W +: SLICE_W]),
            .cout  (cout_w[k]),
            .c_msb (cmsb_w[k])
        );
    end

    // Merge each freshly computed slice into the partial sum it travels with;
    // overflow needs the carry into and out of the MSB, both from the last slice
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k] = sum_in[k];
            sum_d[k][k*SLICE_W +: SLICE_W] = slice_sum_w[k*SLICE_W +: SLICE_W];
        end
        ovf_d = cmsb_w[STAGES-1] ^ cout_w[STAGES-1];
    end

    // Stage registers: cleared on reset, advance together when enabled, hold otherwise
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                sub_q[k] <= 1'b0;
                cy_q[k]  <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= vld_in[k];
                sub_q[k] <= sub_in[k];
                cy_q[k]  <= cout_w[k];
                a_q[k]   <= a_in[k];
                b_q[k]   <= b_in[k];
                sum_q[k] <= sum_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign o_valid    = vld_q[STAGES-1];
    assign o_result   = sum_q[STAGES-1];
    assign o_carry    = cy_q[STAGES-1];
    assign o_overflow = ovf_q;

endmodule
